// File: rtl/bitrev_idx_gen_if.sv
// Handshake/bus bundle between the bit-reversal index sequencer and its neighbours.
// BITREV_IDX_GEN_STALL_CNT_EN adds the o_stall_cycles counter output.
interface bitrev_idx_gen_if #(
  parameter int unsigned D_WIDTH = 32
);
  logic               i_start;
  logic [D_WIDTH-1:0] i_l;
  logic               i_stall;
  logic [D_WIDTH-1:0] o_idx_out;
  logic               o_bitrev_en;
  logic [D_WIDTH-1:0] o_bitrev_l;
  logic               o_last;
  logic               o_out_valid;
  logic               o_out_last;
  logic               o_busy;
  logic               o_done;
  logic               o_cfg_err;
`ifdef BITREV_IDX_GEN_STALL_CNT_EN
  logic [15:0]        o_stall_cycles;

  modport master (
    output i_start, i_l, i_stall,
    input  o_idx_out, o_bitrev_en, o_bitrev_l, o_last, o_out_valid, o_out_last,
           o_busy, o_done, o_cfg_err, o_stall_cycles
  );
  modport slave (
    input  i_start, i_l, i_stall,
    output o_idx_out, o_bitrev_en, o_bitrev_l, o_last, o_out_valid, o_out_last,
           o_busy, o_done, o_cfg_err, o_stall_cycles
  );
`else
  modport master (
    output i_start, i_l, i_stall,
    input  o_idx_out, o_bitrev_en, o_bitrev_l, o_last, o_out_valid, o_out_last,
           o_busy, o_done, o_cfg_err
  );
  modport slave (
    input  i_start, i_l, i_stall,
    output o_idx_out, o_bitrev_en, o_bitrev_l, o_last, o_out_valid, o_out_last,
           o_busy, o_done, o_cfg_err
  );
`endif
endinterface

// File: rtl/bitrev_idx_gen.sv
// Index sequencer feeding the bit-reversal stage: issues 0..2^(RADIX_K1*l)-1 with
// stall support, aligned valid/last for the stage's 1-cycle output, and a done pulse.
// Optional: BITREV_IDX_GEN_STALL_CNT_EN adds a saturating stall-cycle counter.
module bitrev_idx_gen #(
  parameter int unsigned D_WIDTH  = 32,
  parameter int unsigned RADIX_K1 = 4,
  parameter int unsigned MAX_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  bitrev_idx_gen_if.slave   bus
);
  localparam int unsigned W_W   = $clog2(MAX_BITS + 1);
  // Largest l whose width RADIX_K1*l still fits MAX_BITS; avoids overflow in RADIX_K1*l.
  localparam int unsigned L_MAX = MAX_BITS / RADIX_K1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [MAX_BITS-1:0] r_cnt;
  logic [W_W-1:0]      r_w;
  logic [D_WIDTH-1:0]  r_bitrev_l;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_done;
  logic                r_cfg_err;

  logic                w_run;
  logic                w_en;
  logic                w_last;
  logic                w_cfg_ok;
  logic [MAX_BITS-1:0] w_cnt_max;

  // Issue decode: enable follows stall directly while running; last flags index N-1.
  assign w_run     = (r_state == S_RUN);
  assign w_en      = w_run & ~bus.i_stall;
  assign w_cnt_max = ~({MAX_BITS{1'b1}} << r_w);
  assign w_last    = w_en & (r_cnt == w_cnt_max);
  assign w_cfg_ok  = (bus.i_l != '0) && (bus.i_l <= D_WIDTH'(L_MAX));

`ifdef BITREV_IDX_GEN_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  // Stall-cycle counter: cleared on accepted start, saturates, holds after the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if ((r_state == S_IDLE) && bus.i_start && w_cfg_ok) begin
      r_stall_cycles <= '0;
    end else if (w_run && bus.i_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign bus.o_stall_cycles = r_stall_cycles;
`endif

  // Sequencer FSM with its counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_w         <= '0;
      r_bitrev_l  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_out_valid <= w_en;
      r_out_last  <= w_last;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            if (w_cfg_ok) begin
              r_bitrev_l <= bus.i_l;
              r_w        <= W_W'(RADIX_K1 * bus.i_l);
              r_cnt      <= '0;
              r_state    <= S_RUN;
            end else begin
              r_cfg_err  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_en) begin
            if (w_last) begin
              r_state <= S_FLUSH;
            end else begin
              r_cnt   <= r_cnt + MAX_BITS'(1);
            end
          end
        end
        S_FLUSH: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_idx_out   = w_run ? D_WIDTH'(r_cnt) : '0;
  assign bus.o_bitrev_en = w_en;
  assign bus.o_last      = w_last;
  assign bus.o_bitrev_l  = r_bitrev_l;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_last  = r_out_last;
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_done      = r_done;
  assign bus.o_cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_bitrev_idx_gen.sv
// Self-checking bench for bitrev_idx_gen: table of run scenarios plus randomized runs,
// each compared cycle by cycle against a trace built from the issue-sequence rules.
module tb_bitrev_idx_gen;
  localparam int unsigned DW   = 32;
  localparam int          MAXC = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitrev_idx_gen_if #(.D_WIDTH(DW)) bus ();

  bitrev_idx_gen #(.D_WIDTH(DW), .RADIX_K1(4), .MAX_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] l;
    int          slo;
    int          shi;
    int          xstart;
    logic [31:0] xl;
    int          abort_c;
    int          last_c;
    int          done_c;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  int exp_bl  = 0;
  int exp_sc  = 0;

  bit stall_v [MAXC];
  bit e_en    [MAXC];
  bit e_last  [MAXC];
  bit e_run   [MAXC];
  bit e_busy  [MAXC];
  bit e_done  [MAXC];
  bit e_ov    [MAXC];
  bit e_ol    [MAXC];
  bit e_cfg   [MAXC];
  int e_idx   [MAXC];

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Builds the expected trace from the rules, applies it and checks every cycle.
  task automatic run_check(input logic [31:0] l, input int xstart, input logic [31:0] xl,
                           input int abort_c, output int obs_last, output int obs_done,
                           output int m_last, output int m_done);
    longint w;
    bit     ok;
    int     n, k, c, end_c, run_sc, cur_bl, cur_sc;
    for (int i = 0; i < MAXC; i++) begin
      e_en[i] = 0; e_last[i] = 0; e_run[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_ov[i] = 0; e_ol[i] = 0; e_cfg[i] = 0; e_idx[i] = 0;
    end
    w  = 64'(4) * longint'(l);
    ok = (w >= 1) && (w <= 16);
    m_last = -1;
    m_done = -1;
    if (ok) begin
      n = 1 << w;
      c = 1;
      k = 0;
      while (k < n && c < MAXC - 3) begin
        e_run[c]  = 1;
        e_busy[c] = 1;
        e_idx[c]  = k;
        if (!stall_v[c]) begin
          e_en[c]   = 1;
          e_last[c] = (k == n - 1);
          k++;
        end
        c++;
      end
      m_last        = c - 1;
      e_busy[c]     = 1;
      e_busy[c + 1] = 1;
      e_done[c + 1] = 1;
      m_done        = c + 1;
      end_c         = m_done;
      for (int j = 1; j <= end_c; j++) begin
        e_ov[j] = e_en[j - 1];
        e_ol[j] = e_last[j - 1];
      end
    end else begin
      e_cfg[1] = 1;
      end_c    = 2;
    end
    if (abort_c >= 0) begin
      end_c = abort_c;
      if (m_last >= abort_c) m_last = -1;
      if (m_done >= abort_c) m_done = -1;
    end
    obs_last = -1;
    obs_done = -1;
    run_sc   = 0;
    for (c = 0; c <= end_c; c++) begin
      @(posedge clk);
      #1;
      bus.i_start = (c == 0) || (c == xstart);
      bus.i_l     = (c == 0) ? l : xl;
      bus.i_stall = stall_v[c];
      if (c == abort_c) rst = 1'b1;
      @(negedge clk);
      if (c == abort_c) begin
        chk("rst_en", c, 32'(bus.o_bitrev_en), 0);
        chk("rst_idx", c, bus.o_idx_out, 0);
        chk("rst_last", c, 32'(bus.o_last), 0);
        chk("rst_ov", c, 32'(bus.o_out_valid), 0);
        chk("rst_ol", c, 32'(bus.o_out_last), 0);
        chk("rst_busy", c, 32'(bus.o_busy), 0);
        chk("rst_done", c, 32'(bus.o_done), 0);
        chk("rst_bl", c, bus.o_bitrev_l, 0);
`ifdef BITREV_IDX_GEN_STALL_CNT_EN
        chk("rst_sc", c, 32'(bus.o_stall_cycles), 0);
`endif
        exp_bl = 0;
        exp_sc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_start = 1'b0;
        return;
      end
      cur_bl = (c >= 1 && ok) ? int'(l) : exp_bl;
      cur_sc = (c == 0 || !ok) ? exp_sc : run_sc;
      chk("bitrev_en", c, 32'(bus.o_bitrev_en), 32'(e_en[c]));
      chk("last", c, 32'(bus.o_last), 32'(e_last[c]));
      chk("idx_out", c, bus.o_idx_out, e_idx[c]);
      chk("out_valid", c, 32'(bus.o_out_valid), 32'(e_ov[c]));
      chk("out_last", c, 32'(bus.o_out_last), 32'(e_ol[c]));
      chk("busy", c, 32'(bus.o_busy), 32'(e_busy[c]));
      chk("done", c, 32'(bus.o_done), 32'(e_done[c]));
      chk("cfg_err", c, 32'(bus.o_cfg_err), 32'(e_cfg[c]));
      chk("bitrev_l", c, bus.o_bitrev_l, cur_bl);
`ifdef BITREV_IDX_GEN_STALL_CNT_EN
      chk("stall_cycles", c, 32'(bus.o_stall_cycles), cur_sc);
`endif
      if (e_run[c] && stall_v[c] && run_sc < 65535) run_sc++;
      if (bus.o_last && obs_last < 0) obs_last = c;
      if (bus.o_done && obs_done < 0) obs_done = c;
    end
    if (ok) begin
      exp_bl = int'(l);
      exp_sc = run_sc;
    end
  endtask

  vec_t        tbl [11];
  logic [31:0] bad_l [4];

  initial begin
    int ol, od, ml, md, sel, xs;
    logic [31:0] rl;
    tbl[0]  = '{32'd1,          -1, -1, -1, 32'd0, -1,  16,  18};
    tbl[1]  = '{32'd1,           6,  8, -1, 32'd0, -1,  19,  21};
    tbl[2]  = '{32'd0,          -1, -1, -1, 32'd0, -1,  -1,  -1};
    tbl[3]  = '{32'd5,          -1, -1, -1, 32'd0, -1,  -1,  -1};
    tbl[4]  = '{32'd1,          -1, -1,  6, 32'd3, -1,  16,  18};
    tbl[5]  = '{32'd1,          -1, -1, -1, 32'd0,  9,  -1,  -1};
    tbl[6]  = '{32'd2,          -1, -1, -1, 32'd0, -1, 256, 258};
    tbl[7]  = '{32'd1,          -1, -1, 18, 32'd2, -1,  16,  18};
    tbl[8]  = '{32'd2,          10, 12, -1, 32'd0, -1, 259, 261};
    tbl[9]  = '{32'd4,          -1, -1, -1, 32'd0, 40,  -1,  -1};
    tbl[10] = '{32'h4000_0001,  -1, -1, -1, 32'd0, -1,  -1,  -1};
    bad_l[0] = 32'd0;
    bad_l[1] = 32'd5;
    bad_l[2] = 32'hFFFF_FFFF;
    bad_l[3] = 32'h4000_0001;

    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_l     = '0;
    bus.i_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 0, 32'(bus.o_busy), 0);
    chk("reset_bl", 0, bus.o_bitrev_l, 0);
    chk("reset_ov", 0, 32'(bus.o_out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int t = 0; t < 11; t++) begin
      for (int i = 0; i < MAXC; i++) stall_v[i] = (i >= tbl[t].slo) && (i <= tbl[t].shi);
      run_check(tbl[t].l, tbl[t].xstart, tbl[t].xl, tbl[t].abort_c, ol, od, ml, md);
      chk($sformatf("vec%0d_last_cycle", t), t, ol, tbl[t].last_c);
      chk($sformatf("vec%0d_done_cycle", t), t, od, tbl[t].done_c);
    end

    for (int r = 0; r < 12; r++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      rl = 32'd1;
      else if (sel < 8) rl = 32'd2;
      else              rl = bad_l[$urandom_range(0, 3)];
      xs = ((rl == 32'd1 || rl == 32'd2) && ($urandom_range(0, 1) == 1)) ? int'($urandom_range(1, 20)) : -1;
      for (int i = 0; i < MAXC; i++) stall_v[i] = ($urandom_range(0, 3) == 0);
      run_check(rl, xs, 32'd1, -1, ol, od, ml, md);
      chk($sformatf("rand%0d_last_cycle", r), r, ol, ml);
      chk($sformatf("rand%0d_done_cycle", r), r, od, md);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
